// File: rtl/elementwise_pkg.sv
// rtl/elementwise_pkg.sv - mode encodings and accumulator clamp bounds for elementwise_alu
package elementwise_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2,
    MODE_MAC = 2'd3
  } mode_e;

  localparam int BOUND_W = 64;

  // Largest / smallest value an acc_w-bit accumulator can hold; callers size-cast to acc_w.
  function automatic logic [BOUND_W-1:0] acc_bound(input int acc_w, input bit is_signed,
                                                   input bit want_max);
    logic [BOUND_W-1:0] one;
    one = {{(BOUND_W-1){1'b0}}, 1'b1};
    if (is_signed) begin
      return want_max ? (one << (acc_w - 1)) - one : (one << (acc_w - 1));
    end
    return want_max ? (one << acc_w) - one : {BOUND_W{1'b0}};
  endfunction

endpackage

// File: rtl/elementwise_lane.sv
// rtl/elementwise_lane.sv - one element's S2 arithmetic, saturation and accumulator
module elementwise_lane
  import elementwise_pkg::*;
#(
  parameter int W      = 8,
  parameter int ACC_W  = 2*W+4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc_we,
  input  logic [1:0]       i_mode,
  input  logic             i_acc_clr,
  input  logic [W-1:0]     i_u,
  input  logic [W-1:0]     i_v,
  output logic [ACC_W-1:0] o_m,
  output logic             o_sat
);

  // One guard bit above ACC_W exposes MAC overflow and unsigned SUB borrow.
  localparam int XW = ACC_W + 1;
  localparam logic [ACC_W-1:0] L_MAX = ACC_W'(acc_bound(ACC_W, SIGNED != 0, 1'b1));
  localparam logic [ACC_W-1:0] L_MIN = ACC_W'(acc_bound(ACC_W, SIGNED != 0, 1'b0));

  logic [ACC_W-1:0] r_acc;

  logic             w_su;
  logic             w_sv;
  logic             w_sacc;
  logic [XW-1:0]    w_ux;
  logic [XW-1:0]    w_vx;
  logic [XW-1:0]    w_prod;
  logic [ACC_W-1:0] w_add;
  logic [XW-1:0]    w_sub;
  logic [XW-1:0]    w_acc_x;
  logic [XW-1:0]    w_mac;
  logic             w_mac_ovf;
  logic [ACC_W-1:0] w_mac_val;

  assign w_su   = (SIGNED != 0) && i_u[W-1];
  assign w_sv   = (SIGNED != 0) && i_v[W-1];
  assign w_sacc = (SIGNED != 0) && r_acc[ACC_W-1];
  assign w_ux   = {{(XW-W){w_su}}, i_u};
  assign w_vx   = {{(XW-W){w_sv}}, i_v};

  // Low XW bits of the product are exact for both signednesses since ACC_W >= 2*W+1.
  assign w_prod  = w_ux * w_vx;
  assign w_add   = w_ux[ACC_W-1:0] + w_vx[ACC_W-1:0];
  assign w_sub   = w_ux - w_vx;
  assign w_acc_x = i_acc_clr ? '0 : {w_sacc, r_acc};
  assign w_mac   = w_acc_x + w_prod;

  assign w_mac_ovf = (SIGNED != 0) ? (w_mac[XW-1] ^ w_mac[XW-2]) : w_mac[XW-1];
  assign w_mac_val = !w_mac_ovf ? w_mac[ACC_W-1:0] :
                     ((SIGNED != 0) && w_mac[XW-1]) ? L_MIN : L_MAX;

  always_comb begin
    o_m   = w_prod[ACC_W-1:0];
    o_sat = 1'b0;
    case (mode_e'(i_mode))
      MODE_MUL: o_m = w_prod[ACC_W-1:0];
      MODE_ADD: o_m = w_add;
      MODE_SUB: begin
        if ((SIGNED == 0) && w_sub[XW-1]) begin
          o_m   = '0;
          o_sat = 1'b1;
        end else begin
          o_m = w_sub[ACC_W-1:0];
        end
      end
      MODE_MAC: begin
        o_m   = w_mac_val;
        o_sat = w_mac_ovf;
      end
      default: o_m = w_prod[ACC_W-1:0];
    endcase
  end

  // A clamped value is stored as-is so later beats keep accumulating from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_acc_we) begin
      r_acc <= w_mac_val;
    end
  end

endmodule

// File: rtl/elementwise_alu.sv
// rtl/elementwise_alu.sv - two-stage elementwise MUL/ADD/SUB/MAC unit with valid/ready on both sides
module elementwise_alu
  import elementwise_pkg::*;
#(
  parameter int N_ELEM = 16,
  parameter int W      = 8,
  parameter int ACC_W  = 2*W+4,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_in_ready,
  input  logic [1:0]              i_mode,
  input  logic                    i_acc_clr,
  input  logic [N_ELEM*W-1:0]     i_mtx_u,
  input  logic [N_ELEM*W-1:0]     i_mtx_v,
  output logic                    o_valid,
  input  logic                    i_out_ready,
  output logic [N_ELEM*ACC_W-1:0] o_mtx_m,
  output logic [N_ELEM-1:0]       o_sat
);

  logic                    r_s1_valid;
  logic [N_ELEM*W-1:0]     r_s1_u;
  logic [N_ELEM*W-1:0]     r_s1_v;
  logic [1:0]              r_s1_mode;
  logic                    r_s1_clr;
  logic                    r_o_valid;
  logic [N_ELEM*ACC_W-1:0] r_o_mtx_m;
  logic [N_ELEM-1:0]       r_o_sat;

  logic                    w_en1;
  logic                    w_en2;
  logic                    w_mac_move;
  logic [N_ELEM*ACC_W-1:0] w_lane_m;
  logic [N_ELEM-1:0]       w_lane_sat;

  // A stage may load when it is empty or the stage after it is draining this cycle.
  assign w_en2      = !r_o_valid || i_out_ready;
  assign w_en1      = !r_s1_valid || w_en2;
  assign w_mac_move = w_en2 && r_s1_valid && (r_s1_mode == MODE_MAC);

  assign o_in_ready = w_en1;
  assign o_valid    = r_o_valid;
  assign o_mtx_m    = r_o_mtx_m;
  assign o_sat      = r_o_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_u     <= '0;
      r_s1_v     <= '0;
      r_s1_mode  <= '0;
      r_s1_clr   <= 1'b0;
    end else if (w_en1) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_u    <= i_mtx_u;
        r_s1_v    <= i_mtx_v;
        r_s1_mode <= i_mode;
        r_s1_clr  <= i_acc_clr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_mtx_m <= '0;
      r_o_sat   <= '0;
    end else if (w_en2) begin
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_mtx_m <= w_lane_m;
        r_o_sat   <= w_lane_sat;
      end
    end
  end

  for (genvar g = 0; g < N_ELEM; g++) begin : g_lane
    elementwise_lane #(
      .W      (W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_acc_we  (w_mac_move),
      .i_mode    (r_s1_mode),
      .i_acc_clr (r_s1_clr),
      .i_u       (r_s1_u[g*W +: W]),
      .i_v       (r_s1_v[g*W +: W]),
      .o_m       (w_lane_m[g*ACC_W +: ACC_W]),
      .o_sat     (w_lane_sat[g])
    );
  end

endmodule

// File: tb/tb_elementwise_alu.sv
// tb/tb_elementwise_alu.sv - directed and random checks of unsigned and signed builds against a reference model
module tb_elementwise_alu;
  import elementwise_pkg::*;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int ACC_W = 20;
  localparam int FW    = N*ACC_W;
  localparam int IW    = N*W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [1:0]    i_mode = '0;
  logic          i_acc_clr = 1'b0;
  logic [IW-1:0] i_mtx_u = '0;
  logic [IW-1:0] i_mtx_v = '0;
  logic          i_out_ready = 1'b1;

  logic          o_in_ready_u, o_valid_u, o_in_ready_s, o_valid_s;
  logic [FW-1:0] o_mtx_m_u, o_mtx_m_s;
  logic [N-1:0]  o_sat_u, o_sat_s;

  always #5 clk = ~clk;

  elementwise_alu #(.N_ELEM(N), .W(W), .ACC_W(ACC_W), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready_u), .i_mode(i_mode),
    .i_acc_clr(i_acc_clr), .i_mtx_u(i_mtx_u), .i_mtx_v(i_mtx_v), .o_valid(o_valid_u),
    .i_out_ready(i_out_ready), .o_mtx_m(o_mtx_m_u), .o_sat(o_sat_u)
  );

  elementwise_alu #(.N_ELEM(N), .W(W), .ACC_W(ACC_W), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready_s), .i_mode(i_mode),
    .i_acc_clr(i_acc_clr), .i_mtx_u(i_mtx_u), .i_mtx_v(i_mtx_v), .o_valid(o_valid_s),
    .i_out_ready(i_out_ready), .o_mtx_m(o_mtx_m_s), .o_sat(o_sat_s)
  );

  typedef struct packed {
    logic [FW-1:0] mu;
    logic [N-1:0]  su;
    logic [FW-1:0] ms;
    logic [N-1:0]  ss;
  } res_t;

  res_t   exp_q[$];
  res_t   obs_q[$];
  longint acc_m[2][N];
  int     n_total = 0;
  int     n_bad = 0;
  logic   obs_rdy, obs_ovalid;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic longint elem(input logic [FW-1:0] f, input int i, input bit sg);
    logic [ACC_W-1:0] x;
    x = f[i*ACC_W +: ACC_W];
    return sg ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic logic [IW-1:0] fill(input logic [W-1:0] val);
    logic [IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = val;
    return r;
  endfunction

  function automatic logic [IW-1:0] rand_mtx();
    logic [IW-1:0] r;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i*W +: W] = 8'hFF;
        1:       r[i*W +: W] = 8'h80;
        2:       r[i*W +: W] = 8'h7F;
        default: r[i*W +: W] = W'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) acc_m[s][i] = 0;
    exp_q.delete();
  endtask

  // Plain integer arithmetic on the element values, clamped to the accumulator range.
  task automatic model_beat(input logic [1:0] md, input logic clr,
                            input logic [IW-1:0] u, input logic [IW-1:0] v);
    res_t e;
    e = '0;
    for (int sg = 0; sg < 2; sg++) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0]     ue, ve;
        logic [ACC_W-1:0] rt;
        longint a, b, r, hi, lo;
        bit s;
        ue = u[i*W +: W];
        ve = v[i*W +: W];
        a  = (sg == 1) ? longint'($signed(ue)) : longint'(ue);
        b  = (sg == 1) ? longint'($signed(ve)) : longint'(ve);
        hi = (sg == 1) ? (longint'(1) << (ACC_W-1)) - 1 : (longint'(1) << ACC_W) - 1;
        lo = (sg == 1) ? -(longint'(1) << (ACC_W-1)) : 0;
        s  = 1'b0;
        case (md)
          2'd0: r = a * b;
          2'd1: r = a + b;
          2'd2: begin
            if (sg == 0 && b > a) begin r = 0; s = 1'b1; end
            else r = a - b;
          end
          default: begin
            r = (clr ? 0 : acc_m[sg][i]) + a * b;
            if (r > hi) begin r = hi; s = 1'b1; end
            else if (r < lo) begin r = lo; s = 1'b1; end
            acc_m[sg][i] = r;
          end
        endcase
        rt = r[ACC_W-1:0];
        if (sg == 1) begin e.ms[i*ACC_W +: ACC_W] = rt; e.ss[i] = s; end
        else         begin e.mu[i*ACC_W +: ACC_W] = rt; e.su[i] = s; end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic v, input logic [1:0] md, input logic clr,
                       input logic [IW-1:0] u, input logic [IW-1:0] vv, input logic ordy);
    @(negedge clk);
    i_valid = v; i_mode = md; i_acc_clr = clr;
    i_mtx_u = u; i_mtx_v = vv; i_out_ready = ordy;
    #1;
    obs_rdy    = o_in_ready_u;
    obs_ovalid = o_valid_u;
    if (o_valid_u) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", FW'(o_valid_u), FW'(0));
      end else begin
        check("valid_s", FW'(o_valid_s), FW'(1));
        check("m_u", o_mtx_m_u, exp_q[0].mu);
        check("sat_u", FW'(o_sat_u), FW'(exp_q[0].su));
        check("m_s", o_mtx_m_s, exp_q[0].ms);
        check("sat_s", FW'(o_sat_s), FW'(exp_q[0].ss));
        if (ordy) begin
          obs_q.push_back({o_mtx_m_u, o_sat_u, o_mtx_m_s, o_sat_s});
          void'(exp_q.pop_front());
        end
      end
    end
    if (v && o_in_ready_u && o_in_ready_s) model_beat(md, clr, u, vv);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cycle(1'b0, 2'd0, 1'b0, '0, '0, 1'b1);
    check("drain_empty", FW'(exp_q.size()), FW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    res_t r;
    logic [IW-1:0] pat;
    logic [IW-1:0] pat_mtx;

    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", FW'(o_valid_u), FW'(0));
    check("rst_m", o_mtx_m_u, FW'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", FW'(o_in_ready_u), FW'(1));

    // MUL of {1,2,3,4} repeated, with latency probe
    for (int i = 0; i < N; i++) pat[i*W +: W] = W'(i % 4 + 1);
    cycle(1'b1, MODE_MUL, 1'b0, pat, pat, 1'b1);
    cycle(1'b0, MODE_MUL, 1'b0, '0, '0, 1'b1);
    check("lat_early", FW'(obs_ovalid), FW'(0));
    cycle(1'b0, MODE_MUL, 1'b0, '0, '0, 1'b1);
    check("lat_valid", FW'(obs_ovalid), FW'(1));
    r = obs_q[obs_q.size()-1];
    for (int i = 0; i < N; i++)
      check("mul_sq", FW'(elem(r.mu, i, 0)), FW'(longint'((i % 4 + 1) * (i % 4 + 1))));
    check("mul_sat", FW'(r.su), FW'(0));

    // signed MUL -128*-128, SUB 5-7 in both builds
    cycle(1'b1, MODE_MUL, 1'b0, fill(8'h80), fill(8'h80), 1'b1);
    cycle(1'b1, MODE_SUB, 1'b0, fill(8'd5), fill(8'd7), 1'b1);
    drain();
    r = obs_q[obs_q.size()-2];
    check("smul_m", FW'(elem(r.ms, 3, 1)), FW'(longint'(16384)));
    r = obs_q[obs_q.size()-1];
    check("ssub_m", FW'(elem(r.ms, 0, 1)), FW'(longint'(-2)));
    check("ssub_sat", FW'(r.ss), FW'(0));
    check("usub_m", FW'(elem(r.mu, 0, 0)), FW'(0));
    check("usub_sat", FW'(r.su), FW'({N{1'b1}}));

    // MAC saturation: 17 beats of 255*255 then a cleared 2*2
    base = obs_q.size();
    for (int k = 1; k <= 17; k++) cycle(1'b1, MODE_MAC, k == 1, fill(8'hFF), fill(8'hFF), 1'b1);
    drain();
    for (int k = 1; k <= 17; k++) begin
      r = obs_q[base + k - 1];
      check("mac_m", FW'(elem(r.mu, 0, 0)), FW'((k <= 16) ? longint'(65025 * k) : longint'(1048575)));
      check("mac_sat", FW'(r.su), FW'((k == 17) ? {N{1'b1}} : {N{1'b0}}));
    end
    cycle(1'b1, MODE_MAC, 1'b1, fill(8'd2), fill(8'd2), 1'b1);
    drain();
    r = obs_q[obs_q.size()-1];
    check("mac_clr_m", FW'(elem(r.mu, 5, 0)), FW'(longint'(4)));
    check("mac_clr_sat", FW'(r.su), FW'(0));

    // backpressure: 4 beats, out_ready low for 3 cycles from the first o_valid
    begin
      int idx;
      idx  = 0;
      base = obs_q.size();
      for (int c = 0; c < 30 && idx < 4; c++) begin
        cycle(1'b1, MODE_MUL, 1'b0, fill(W'(idx + 1)), fill(W'(idx + 1)), !(c >= 2 && c < 5));
        if (c >= 2 && c < 5) begin
          check("bp_in_ready", FW'(obs_rdy), FW'(0));
          check("bp_valid", FW'(obs_ovalid), FW'(1));
        end
        if (obs_rdy) idx++;
      end
      drain();
      check("bp_count", FW'(obs_q.size() - base), FW'(4));
      for (int k = 0; k < 4 && base + k < obs_q.size(); k++)
        check("bp_order", FW'(elem(obs_q[base + k].mu, 0, 0)), FW'(longint'((k + 1) * (k + 1))));
    end

    // interleaved MAC / ADD / MAC
    cycle(1'b1, MODE_MAC, 1'b1, fill(8'd3), fill(8'd3), 1'b1);
    cycle(1'b1, MODE_ADD, 1'b0, fill(8'd1), fill(8'd1), 1'b1);
    cycle(1'b1, MODE_MAC, 1'b0, fill(8'd2), fill(8'd2), 1'b1);
    drain();
    check("il_mac1", FW'(elem(obs_q[obs_q.size()-3].mu, 0, 0)), FW'(longint'(9)));
    check("il_add", FW'(elem(obs_q[obs_q.size()-2].mu, 0, 0)), FW'(longint'(2)));
    check("il_mac2", FW'(elem(obs_q[obs_q.size()-1].mu, 0, 0)), FW'(longint'(13)));

    // reset with both stages full
    cycle(1'b1, MODE_MAC, 1'b1, fill(8'd5), fill(8'd5), 1'b0);
    cycle(1'b1, MODE_MUL, 1'b0, fill(8'd6), fill(8'd6), 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_valid", FW'(o_valid_u), FW'(0));
    check("mrst_m", o_mtx_m_u, FW'(0));
    check("mrst_sat", FW'(o_sat_u), FW'(0));
    check("mrst_valid_s", FW'(o_valid_s), FW'(0));
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_in_ready", FW'(o_in_ready_u), FW'(1));
    cycle(1'b1, MODE_MAC, 1'b0, fill(8'd3), fill(8'd7), 1'b1);
    drain();
    check("mrst_mac", FW'(elem(obs_q[obs_q.size()-1].mu, 0, 0)), FW'(longint'(21)));

    // random traffic
    for (int c = 0; c < 600; c++) begin
      pat_mtx = rand_mtx();
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
            pat_mtx, rand_mtx(), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
